pipe_stage_chain: RTL and testbench

//  Parametrised chain of NUM_STAGES pipeline registers (IF/ID .. MEM/WB) with per-stage valid bits.

---
 rtl/pipe_stage_chain.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_chain.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//   Chain of NUM_STAGES pipeline registers with per-stage valid bits, placed
//   between CPU datapath stages (IF/ID .. MEM/WB). Stage 0 is the youngest
//   (input side), stage NUM_STAGES-1 the oldest (output side). Supports a
//   backward-propagating stall, flush with bubble insertion, a global freeze
//   and saturating retired/bubble counters. Payloads are opaque.
//
// Ports
//   clk          in   rising-edge clock
//   arst_n       in   synchronous active-low reset (overrides everything)
//   enable       in   0 freezes the whole chain and both counters
//   in_valid     in   stage-0 source holds a valid item
//   in_data      in   stage-0 source payload
//   in_ready     out  stage 0 accepts this cycle (combinational)
//   stall_req    in   bit k: stage k (and all younger stages) must not advance
//   flush_req    in   bit k: kill stage k and all younger stages
//   cnt_clr      in   clear both counters (ignored while enable=0)
//   stage_valid  out  valid bit of each stage
//   stage_data   out  payloads, stage k at [k*DATA_W +: DATA_W]
//   out_valid    out  valid bit of the last stage
//   out_data     out  payload of the last stage
//   retired_cnt  out  cycles with a valid item in the last stage (saturating)
//   bubble_cnt   out  cycles with an invalid last stage (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter int unsigned NUM_STAGES          = 4,
  parameter int unsigned DATA_W              = 32,
  parameter int unsigned CNT_W               = 16,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         enable,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic [NUM_STAGES-1:0]        stall_req,
  input  logic [NUM_STAGES-1:0]        flush_req,
  input  logic                         cnt_clr,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [CNT_W-1:0]             retired_cnt,
  output logic [CNT_W-1:0]             bubble_cnt
);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]     data_q [NUM_STAGES];
  logic [DATA_W-1:0]     data_d [NUM_STAGES];
  logic [CNT_W-1:0]      retired_q, retired_d;
  logic [CNT_W-1:0]      bubble_q, bubble_d;

  // hold/kill of stage k is the OR over stage k and every older stage, so a
  // stall or flush request reaches back towards the input side.
  logic [NUM_STAGES-1:0] hold, kill;

  always_comb begin
    hold = '0;
    kill = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      for (int unsigned j = k; j < NUM_STAGES; j++) begin
        hold[k] = hold[k] | stall_req[j];
        kill[k] = kill[k] | flush_req[j];
      end
    end
  end

  assign in_ready = enable & ~hold[0] & ~kill[0];

  // Stage next-state: kill beats hold beats advance.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (enable) begin
      if (kill[0]) begin
        valid_d[0] = 1'b0;
        if (CLEAR_DATA_ON_FLUSH) data_d[0] = '0;
      end else if (!hold[0]) begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
      end
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        if (kill[k]) begin
          valid_d[k] = 1'b0;
          if (CLEAR_DATA_ON_FLUSH) data_d[k] = '0;
        end else if (!hold[k]) begin
          // A held predecessor leaves a bubble behind; data is copied anyway.
          valid_d[k] = valid_q[k-1] & ~hold[k-1];
          data_d[k]  = data_q[k-1];
        end
      end
    end
  end

  // Counters look at the pre-edge last-stage valid bit and saturate.
  always_comb begin
    retired_d = retired_q;
    bubble_d  = bubble_q;
    if (enable) begin
      if (cnt_clr) begin
        retired_d = '0;
        bubble_d  = '0;
      end else if (valid_q[NUM_STAGES-1]) begin
        if (retired_q != '1) retired_d = retired_q + 1'b1;
      end else begin
        if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      valid_q   <= '0;
      retired_q <= '0;
      bubble_q  <= '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      retired_q <= retired_d;
      bubble_q  <= bubble_d;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    stage_data = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      stage_data[k*DATA_W +: DATA_W] = data_q[k];
    end
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[NUM_STAGES-1];
  assign out_data    = data_q[NUM_STAGES-1];
  assign retired_cnt = retired_q;
  assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//   Directed bench for pipe_stage_chain: a 4-stage, 32-bit, 16-bit-counter
//   instance for the datapath behaviour, plus a 4-bit-counter instance for
//   counter saturation. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

  logic         clk;
  logic         rst_n;

  logic         enable;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [3:0]   stall_req;
  logic [3:0]   flush_req;
  logic         cnt_clr;
  logic [3:0]   stage_valid;
  logic [127:0] stage_data;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [15:0]  retired_cnt;
  logic [15:0]  bubble_cnt;

  logic         s_cnt_clr;
  logic         s_in_ready;
  logic [3:0]   s_stage_valid;
  logic [31:0]  s_stage_data;
  logic         s_out_valid;
  logic [7:0]   s_out_data;
  logic [3:0]   s_retired_cnt;
  logic [3:0]   s_bubble_cnt;

  int total;
  int bad;

  pipe_stage_chain #(
    .NUM_STAGES(4), .DATA_W(32), .CNT_W(16), .CLEAR_DATA_ON_FLUSH(1'b1)
  ) dut (
    .clk(clk), .arst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data),
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_chain #(
    .NUM_STAGES(4), .DATA_W(8), .CNT_W(4), .CLEAR_DATA_ON_FLUSH(1'b1)
  ) dut_sat (
    .clk(clk), .arst_n(rst_n), .enable(1'b1),
    .in_valid(1'b0), .in_data(8'h00), .in_ready(s_in_ready),
    .stall_req(4'b0000), .flush_req(4'b0000), .cnt_clr(s_cnt_clr),
    .stage_valid(s_stage_valid), .stage_data(s_stage_data),
    .out_valid(s_out_valid), .out_data(s_out_data),
    .retired_cnt(s_retired_cnt), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    stall_req = 4'b0000;
    flush_req = 4'b0000;
    cnt_clr   = 1'b0;
    s_cnt_clr = 1'b0;

    // T1 reset with in_valid=1
    tick(); tick();
    chk("rst_valid",   128'(stage_valid), 'h0);
    chk("rst_data",    stage_data, '0);
    chk("rst_retired", 128'(retired_cnt), 'h0);
    chk("rst_bubble",  128'(bubble_cnt), 'h0);
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_ready", 128'(in_ready), 'h1);
    tick();                                            // bubble=1

    // T2 stream 11,22,33,44
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_data = 32'h33; tick();
    in_data = 32'h44; tick();
    chk("t2_out_valid", 128'(out_valid), 'h1);
    chk("t2_out_11",    128'(out_data), 'h11);
    chk("t2_stages",    stage_data, {32'h11, 32'h22, 32'h33, 32'h44});
    in_valid = 1'b0; in_data = '0;
    tick(); chk("t2_out_22", 128'(out_data), 'h22);
    tick(); chk("t2_out_33", 128'(out_data), 'h33);
    tick(); chk("t2_out_44", 128'(out_data), 'h44);
    tick();
    chk("t2_drained", 128'(out_valid), 'h0);
    chk("t2_retired", 128'(retired_cnt), 'd4);
    chk("t2_bubble",  128'(bubble_cnt), 'd5);

    // T3 stall on stage 1 for two cycles
    in_valid = 1'b1; in_data = 32'hA1; tick();
    in_data = 32'hA2; tick();
    stall_req = 4'b0010; in_data = 32'hA3;
    #1;
    chk("t3_ready_stalled", 128'(in_ready), 'h0);
    tick();
    chk("t3_valid_s1", 128'(stage_valid), 'b0011);
    chk("t3_data_s1",  stage_data, {32'h0, 32'hA1, 32'hA1, 32'hA2});
    tick();
    chk("t3_valid_s2", 128'(stage_valid), 'b0011);
    chk("t3_data_s2",  stage_data, {32'hA1, 32'hA1, 32'hA1, 32'hA2});
    chk("t3_bubble_s2", 128'(bubble_cnt), 'd9);
    stall_req = 4'b0000;
    tick();
    chk("t3_valid_rel", 128'(stage_valid), 'b0111);
    chk("t3_data_rel",  stage_data, {32'hA1, 32'hA1, 32'hA2, 32'hA3});
    in_data = 32'hA4; tick();
    chk("t3_out_a1", 128'(out_data), 'hA1);
    in_valid = 1'b0; in_data = '0;
    tick(); chk("t3_out_a2", 128'(out_data), 'hA2);
    tick(); chk("t3_out_a3", 128'(out_data), 'hA3);
    tick(); chk("t3_out_a4", 128'(out_data), 'hA4);
    tick();
    chk("t3_retired", 128'(retired_cnt), 'd8);
    chk("t3_bubble",  128'(bubble_cnt), 'd11);

    // T4 flush on stage 1 beats stall on stage 2
    in_valid = 1'b1; in_data = 32'hB1; tick();
    in_data = 32'hB2; tick();
    in_data = 32'hB3; tick();
    in_data = 32'hB4; tick();
    chk("t4_full", 128'(stage_valid), 'b1111);
    stall_req = 4'b0100; flush_req = 4'b0010; in_data = 32'hB5;
    #1;
    chk("t4_ready_flush", 128'(in_ready), 'h0);
    tick();
    chk("t4_valid",   128'(stage_valid), 'b0100);
    chk("t4_data",    stage_data, {32'hB2, 32'hB2, 32'h0, 32'h0});
    chk("t4_retired", 128'(retired_cnt), 'd9);
    stall_req = 4'b0000; flush_req = 4'b0000; in_valid = 1'b0; in_data = '0;
    tick();
    chk("t4_out_valid", 128'(out_valid), 'h1);
    chk("t4_out_b2",    128'(out_data), 'hB2);
    tick();
    chk("t4_retired2", 128'(retired_cnt), 'd10);
    chk("t4_bubble2",  128'(bubble_cnt), 'd16);
    chk("t4_empty",    128'(stage_valid), 'h0);

    // T5 freeze for three cycles, cnt_clr ignored meanwhile
    in_valid = 1'b1; in_data = 32'hC1; tick();
    in_data = 32'hC2; tick();
    enable = 1'b0; in_data = 32'hC3;
    #1;
    chk("t5_ready_frozen", 128'(in_ready), 'h0);
    tick();
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0; tick();
    chk("t5_valid",   128'(stage_valid), 'b0011);
    chk("t5_data",    stage_data, {32'h0, 32'h0, 32'hC1, 32'hC2});
    chk("t5_retired", 128'(retired_cnt), 'd10);
    chk("t5_bubble",  128'(bubble_cnt), 'd18);
    enable = 1'b1; tick();
    chk("t5_resume_valid", 128'(stage_valid), 'b0111);
    chk("t5_resume_bub",   128'(bubble_cnt), 'd19);
    in_data = 32'hC4; tick();
    chk("t5_out_c1", 128'(out_data), 'hC1);
    in_valid = 1'b0; in_data = '0;
    tick(); chk("t5_out_c2", 128'(out_data), 'hC2);
    tick(); chk("t5_out_c3", 128'(out_data), 'hC3);
    tick(); chk("t5_out_c4", 128'(out_data), 'hC4);
    tick();
    chk("t5_retired2", 128'(retired_cnt), 'd14);
    chk("t5_bubble2",  128'(bubble_cnt), 'd20);

    // counter clear while enabled
    cnt_clr = 1'b1; tick();
    chk("clr_retired", 128'(retired_cnt), 'd0);
    chk("clr_bubble",  128'(bubble_cnt), 'd0);
    cnt_clr = 1'b0; tick();
    chk("clr_count_on", 128'(bubble_cnt), 'd1);

    // reset mid-stream discards in-flight items
    in_valid = 1'b1; in_data = 32'hD1; tick();
    in_data = 32'hD2; tick();
    chk("mrst_before", 128'(stage_valid), 'b0011);
    rst_n = 1'b0; tick();
    chk("mrst_valid", 128'(stage_valid), 'h0);
    chk("mrst_data",  stage_data, '0);
    chk("mrst_ret",   128'(retired_cnt), 'd0);
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (4) tick();
    chk("mrst_after_valid", 128'(stage_valid), 'h0);
    chk("mrst_after_ret",   128'(retired_cnt), 'd0);
    chk("mrst_after_bub",   128'(bubble_cnt), 'd4);

    // T6 saturation on the 4-bit counter instance
    s_cnt_clr = 1'b1; tick();
    chk("t6_clr_bub", 128'(s_bubble_cnt), 'd0);
    chk("t6_clr_ret", 128'(s_retired_cnt), 'd0);
    s_cnt_clr = 1'b0;
    repeat (14) tick();
    chk("t6_bub_14", 128'(s_bubble_cnt), 'd14);
    tick();
    chk("t6_bub_15", 128'(s_bubble_cnt), 'd15);
    repeat (5) tick();
    chk("t6_bub_sat",  128'(s_bubble_cnt), 'd15);
    chk("t6_ret_idle", 128'(s_retired_cnt), 'd0);
    chk("t6_idle_valid", 128'({s_out_valid, s_stage_valid}), 'h0);
    chk("t6_idle_data",  128'({s_out_data, s_stage_data}), 'h0);
    chk("t6_idle_ready", 128'(s_in_ready), 'h1);
    s_cnt_clr = 1'b1; tick();
    chk("t6_clr2_bub", 128'(s_bubble_cnt), 'd0);
    chk("t6_clr2_ret", 128'(s_retired_cnt), 'd0);
    s_cnt_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
